// File: rtl/cordic_cos_seq.sv
// Sequential CORDIC cosine: float radians in, Q2.30 cos out.
// One micro-rotation per enabled clock; x holds the cosine at the end.
module cordic_cos_seq #(
    parameter int ITERS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    output logic [31:0] theta
);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    localparam logic [31:0] K_INIT = 32'h26DD3B6A;
    localparam logic [4:0]  LAST   = 5'(ITERS - 1);

    state_t      state_q, state_d;
    logic [4:0]  i_q, i_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [31:0] z_q, z_d;
    logic [31:0] res_q, res_d;
    logic [31:0] th_q, th_d;

    logic [31:0] conv;
    logic [31:0] xs, ys, at;
    logic [31:0] xn, yn, zn;

    // round(atan(2^-k) * 2^30); from k=10 on the value rounds to 2^(30-k)
    function automatic logic [31:0] atan_lut(input logic [4:0] k);
        logic [31:0] v;
        case (k)
            5'd0:    v = 32'h3243F6A9;
            5'd1:    v = 32'h1DAC6705;
            5'd2:    v = 32'h0FADBAFD;
            5'd3:    v = 32'h07F56EA7;
            5'd4:    v = 32'h03FEAB77;
            5'd5:    v = 32'h01FFD55C;
            5'd6:    v = 32'h00FFFAAB;
            5'd7:    v = 32'h007FFF55;
            5'd8:    v = 32'h003FFFEB;
            5'd9:    v = 32'h001FFFFD;
            default: v = (k <= 5'd29) ? (32'd1 << (5'd30 - k)) : 32'd0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] f2q(input logic [31:0] f);
        logic [7:0]  e;
        logic [31:0] m;
        logic [31:0] mag;
        e = f[30:23];
        m = {8'd0, 1'b1, f[22:0]};
        if (e < 8'd97)
            mag = 32'd0;
        else if (e < 8'd120)
            mag = m >> (8'd120 - e);
        else if (e < 8'd128)
            mag = m << (e - 8'd120);
        else
            mag = 32'h7FFFFFFF;
        return f[31] ? (32'd0 - mag) : mag;
    endfunction

    assign conv = f2q(dataa);
    assign xs   = $signed(x_q) >>> i_q;
    assign ys   = $signed(y_q) >>> i_q;
    assign at   = atan_lut(i_q);

    // z sign picks the rotation direction
    always_comb begin
        xn = x_q - ys;
        yn = y_q + xs;
        zn = z_q - at;
        if (z_q[31]) begin
            xn = x_q + ys;
            yn = y_q - xs;
            zn = z_q + at;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        res_d   = res_q;
        th_d    = th_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ITER;
                    th_d    = conv;
                    z_d     = conv;
                    x_d     = K_INIT;
                    y_d     = 32'd0;
                    i_d     = 5'd0;
                end
            end
            ITER: begin
                x_d = xn;
                y_d = yn;
                z_d = zn;
                i_d = i_q + 5'd1;
                if (i_q == LAST) begin
                    state_d = DONE;
                    res_d   = xn;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= 5'd0;
            x_q     <= 32'd0;
            y_q     <= 32'd0;
            z_q     <= 32'd0;
            res_q   <= 32'd0;
            th_q    <= 32'd0;
        end else if (clk_en) begin
            state_q <= state_d;
            i_q     <= i_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            res_q   <= res_d;
            th_q    <= th_d;
        end
    end

    assign result = res_q;
    assign theta  = th_q;
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_cordic_cos_seq.sv
// Bench for cordic_cos_seq: scoreboard of cosine results against $cos,
// plus latency, stall, ignored-restart, done-stretch and async reset.
module tb_cordic_cos_seq;

    localparam int ITERS = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] result;
    logic [31:0] theta;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] exp;
        logic [31:0] tol;
        logic        use_it;
    } sb_t;

    sb_t sbq[$];
    bit  seen = 1'b0;

    cordic_cos_seq #(.ITERS(ITERS)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .result (result),
        .done   (done),
        .theta  (theta)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp, input int tol = 0);
        longint d;
        checks++;
        d = longint'($signed(obs)) - longint'($signed(exp));
        if (d < 0) d = -d;
        if (d > longint'(tol)) begin
            errors++;
            $display("FAIL %s got %08h want %08h tol %0d",
                     tag, obs, exp, tol);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            seen <= 1'b0;
        end else if (done && !seen) begin
            seen <= 1'b1;
            if (sbq.size() == 0) begin
                check("sb_spurious", 32'd1, 32'd0);
            end else begin
                if (sbq[0].use_it)
                    check("cos", result, sbq[0].exp, int'(sbq[0].tol));
                void'(sbq.pop_front());
            end
        end else if (!done) begin
            seen <= 1'b0;
        end
    end

    task automatic op(input logic [31:0] a, input real ang,
                      input bit use_cos, input int stall,
                      input int hold, input bit restart);
        real         t;
        logic [31:0] et;
        sb_t         s;
        int          n;
        t = ang * 1073741824.0;
        if (t >= 2147483647.0)
            et = 32'h7FFFFFFF;
        else if (t <= -2147483647.0)
            et = 32'h80000001;
        else
            et = $rtoi(t);
        s.exp    = $rtoi($cos(ang) * 1073741824.0);
        s.tol    = 32'h400;
        s.use_it = use_cos;
        sbq.push_back(s);
        dataa = a;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("theta", theta, et);
        n = 0;
        while (!done && n < 400) begin
            start = restart && (n == 4);
            if (start) dataa = 32'h3F000000;
            clk_en = !(n >= 8 && n < 8 + stall);
            @(posedge clk); #1;
            n++;
        end
        start  = 1'b0;
        clk_en = 1'b1;
        check("latency", n, ITERS + stall);
        check("theta_hold", theta, et);
        for (int k = 0; k < hold; k++) begin
            clk_en = 1'b0;
            @(posedge clk); #1;
            check("done_hold", {31'd0, done}, 32'd1);
        end
        clk_en = 1'b1;
        @(posedge clk); #1;
        check("done_fall", {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          e;
        logic [22:0] m;
        real         ang;

        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_theta", theta, 32'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        op(32'h3F800000, 1.0, 1'b1, 0, 0, 1'b0);
        op(32'hBF800000, -1.0, 1'b1, 0, 0, 1'b0);
        op(32'h3F000000, 0.5, 1'b1, 0, 0, 1'b0);
        op(32'h30800000, 1.0 / 1073741824.0, 1'b1, 0, 0, 1'b0);
        op(32'h00000000, 0.0, 1'b1, 0, 0, 1'b0);
        op(32'h2F800000, 1.0 / 4294967296.0, 1'b1, 0, 0, 1'b0);
        op(32'h40000000, 2.0, 1'b0, 0, 0, 1'b0);
        op(32'h3F800000, 1.0, 1'b1, 5, 0, 1'b1);
        op(32'h3F000000, 0.5, 1'b1, 0, 3, 1'b0);

        for (int r = 0; r < 6; r++) begin
            e = $urandom_range(100, 127);
            m = 23'($urandom);
            if (e == 127) m[22] = 1'b0;
            a = {1'($urandom_range(0, 1)), 8'(e), m};
            ang = (1.0 + real'(m) / 8388608.0) * (2.0 ** real'(e - 127));
            if (a[31]) ang = -ang;
            op(a, ang, 1'b1, 0, 0, 1'b0);
        end

        dataa = 32'h3F800000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_theta", theta, 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        op(32'h3F800000, 1.0, 1'b1, 0, 0, 1'b0);

        repeat (2) @(posedge clk);
        check("sb_left", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
